// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int FETCH_XLEN = 32;

    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam logic [FETCH_XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0]            instr;
        logic [FETCH_XLEN-1:0]  pc;
        logic [FETCH_XLEN-1:0]  pcPlus4;
        logic                   valid;
    } if_id_t;

    // Contents of the IF/ID register when Decode holds no real instruction.
    localparam if_id_t IF_ID_BUBBLE = '{
        instr:   NOP,
        pc:      '0,
        pcPlus4: '0,
        valid:   1'b0
    };

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Reset and flush both load the bubble value;
// flush takes priority over the capture enable.
module if_id_reg
    import fetch_pkg::*;
#(
    parameter if_id_t BUBBLE = IF_ID_BUBBLE
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   flush,
    input  logic   en,
    input  if_id_t d,
    output if_id_t q
);

    // Bubble on reset or flush, otherwise capture when enabled, else hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= BUBBLE;
        end else if (flush) begin
            q <= BUBBLE;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, next-PC select, IF/ID register,
// wrong-path squash, misaligned-target flag and fetch/redirect counters.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   BOOT  | first cycle after reset: D loads a bubble, PC moves only on a
//         | redirect, giving imem one cycle to settle at RESET_PC
//   RUN   | normal fetch with stall/flush/redirect handling
//
// XLEN must match the width fixed in fetch_pkg (FETCH_XLEN), since the
// IF/ID record is a packed struct shared with the sub-module.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int              XLEN     = FETCH_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stallF,
    input  logic            stallD,
    input  logic            flushD,
    input  logic            pcSrcE,
    input  logic [XLEN-1:0] pcTargetE,
    input  logic [31:0]     instrF,
    output logic [XLEN-1:0] pcF,
    output logic [XLEN-1:0] pcD,
    output logic [XLEN-1:0] pcPlus4D,
    output logic [31:0]     instrD,
    output logic            validD,
    output logic            misalignF,
    output logic [31:0]     fetchCount,
    output logic [31:0]     redirectCount
);

    fetch_state_t    state;
    logic [XLEN-1:0] pcPlus4F;
    logic [XLEN-1:0] pcNext;
    logic            inBoot;
    logic            pcEn;
    logic            ifIdFlush;
    logic            ifIdEn;
    logic            capture;
    if_id_t          ifIdIn;
    if_id_t          ifIdOut;

    // Next-PC select and load/capture qualifiers for this cycle.
    always_comb begin
        pcPlus4F  = pcF + XLEN'(4);
        pcNext    = pcSrcE ? {pcTargetE[XLEN-1:2], 2'b00} : pcPlus4F;
        inBoot    = (state == BOOT);
        // A redirect always moves the PC, even under stallF or in BOOT.
        pcEn      = pcSrcE || (!inBoot && !stallF);
        ifIdFlush = inBoot || flushD || pcSrcE;
        ifIdEn    = !stallD;
        capture   = !ifIdFlush && ifIdEn;
        ifIdIn    = '{instr: instrF, pc: pcF, pcPlus4: pcPlus4F, valid: 1'b1};
    end

    // BOOT lasts exactly one cycle after reset, then RUN until the next reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= BOOT;
        end else begin
            state <= RUN;
        end
    end

    // Program counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            pcF <= RESET_PC;
        end else if (pcEn) begin
            pcF <= pcNext;
        end
    end

    // Sticky flag for a redirect target that is not word aligned.
    always_ff @(posedge clk) begin
        if (reset) begin
            misalignF <= 1'b0;
        end else if (pcSrcE && (pcTargetE[1:0] != 2'b00)) begin
            misalignF <= 1'b1;
        end
    end

    // Event counters; both wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetchCount    <= '0;
            redirectCount <= '0;
        end else begin
            if (capture) begin
                fetchCount <= fetchCount + 32'd1;
            end
            if (pcSrcE) begin
                redirectCount <= redirectCount + 32'd1;
            end
        end
    end

    if_id_reg #(
        .BUBBLE (IF_ID_BUBBLE)
    ) uIfId (
        .clk   (clk),
        .reset (reset),
        .flush (ifIdFlush),
        .en    (ifIdEn),
        .d     (ifIdIn),
        .q     (ifIdOut)
    );

    assign instrD   = ifIdOut.instr;
    assign pcD      = ifIdOut.pc;
    assign pcPlus4D = ifIdOut.pcPlus4;
    assign validD   = ifIdOut.valid;

endmodule
